// File: rtl/iic_bit_phy.sv
// Bit-level IIC engine: one START/STOP/WRITE/READ primitive per command, split into
// four CLK_DIV-cycle phases, with open-drain line control, clock stretching and arbitration.
module iic_bit_phy #(
  parameter int unsigned CLK_DIV = 250,
  parameter int unsigned DIV_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       arb_lost,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;
  typedef enum logic [1:0] {CMD_START = 2'b00, CMD_STOP = 2'b01,
                            CMD_WRITE = 2'b10, CMD_READ = 2'b11} cmd_t;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  state_t           r_state;
  cmd_t             r_cmd;
  logic             r_bit;
  logic             r_lost;
  logic [DIV_W-1:0] r_cnt;
  logic             r_scl_meta, r_scl_sync;
  logic             r_sda_meta, r_sda_sync;
  logic             r_scl_oe, r_sda_oe;
  logic             r_rsp_valid, r_rsp_bit, r_arb_lost;

  cmd_t w_cmd;
  logic w_data_cmd;
  logic w_last;
  logic w_hold;
  logic w_sample;

  assign w_cmd      = cmd_t'(cmd);
  assign w_data_cmd = (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ);
  assign w_last     = (r_cnt == LAST);
  // A slave holding SCL low freezes the high phase before it starts counting
  assign w_hold     = (r_state == PH_B) && (r_cnt == '0) && !r_scl_sync;
  assign w_sample   = (r_state == PH_C) && (r_cnt == '0) && w_data_cmd;

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_bit   = r_rsp_bit;
  assign arb_lost  = r_arb_lost;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
    end else begin
      r_scl_meta <= scl_i;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= sda_i;
      r_sda_sync <= r_sda_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd       <= CMD_START;
      r_bit       <= 1'b0;
      r_lost      <= 1'b0;
      r_cnt       <= '0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_bit   <= 1'b0;
      r_arb_lost  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_arb_lost  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_cmd   <= w_cmd;
            r_bit   <= cmd_bit;
            r_lost  <= 1'b0;
            r_cnt   <= '0;
            r_state <= PH_A;
            // Phase A drive is applied on the accept edge; START keeps SCL as it was
            case (w_cmd)
              CMD_START: r_sda_oe <= 1'b0;
              CMD_STOP: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= 1'b1;
              end
              CMD_WRITE: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= ~cmd_bit;
              end
              default: begin
                r_scl_oe <= 1'b1;
                r_sda_oe <= 1'b0;
              end
            endcase
          end
        end
        default: begin
          if (w_sample) begin
            r_rsp_bit <= r_sda_sync;
            if ((r_cmd == CMD_WRITE) && r_bit && !r_sda_sync) begin
              r_lost   <= 1'b1;
              r_sda_oe <= 1'b0;
            end
          end
          if (w_hold) begin
            r_cnt <= '0;
          end else if (!w_last) begin
            r_cnt <= r_cnt + DIV_W'(1);
          end else begin
            r_cnt <= '0;
            case (r_state)
              PH_A: begin
                r_state  <= PH_B;
                r_scl_oe <= 1'b0;
                if (!w_data_cmd) r_sda_oe <= (r_cmd == CMD_STOP);
              end
              PH_B: begin
                r_state  <= PH_C;
                r_scl_oe <= 1'b0;
                if (!w_data_cmd) r_sda_oe <= (r_cmd == CMD_START);
              end
              PH_C: begin
                r_state  <= PH_D;
                r_scl_oe <= (r_cmd != CMD_STOP);
                if (!w_data_cmd) r_sda_oe <= (r_cmd == CMD_START);
              end
              default: begin
                r_state     <= IDLE;
                r_rsp_valid <= 1'b1;
                r_arb_lost  <= r_lost;
                if (r_lost) begin
                  r_scl_oe <= 1'b0;
                  r_sda_oe <= 1'b0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_bit_phy.sv
// Bench for iic_bit_phy: wired-AND bus with a modelled slave, a directed vector table,
// reset-abort sequences and random commands checked against a bus-level model.
module tb_iic_bit_phy;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned LIMIT   = 4 * CLK_DIV + 64;
  localparam int unsigned LAT0    = 4 * CLK_DIV;
  localparam int unsigned LAT2    = 4 * CLK_DIV + 2;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_bit;
  logic       rsp_valid, rsp_bit, arb_lost, busy;
  logic       scl_oe, sda_oe;
  logic       scl_line, sda_line;
  logic       slave_scl_low, slave_sda_low;
  logic       stretch_arm;
  int unsigned stretch_len;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic m_scl, m_sda, m_rsp;

  typedef struct {
    logic [1:0]  c;
    logic        b;
    logic        sl;
    int unsigned s;
    int unsigned lat;
    logic        rb;
    logic        arb;
    logic        scl;
    logic        sda;
  } vec_t;
  vec_t vecs [12];

  assign scl_line = ~(scl_oe | slave_scl_low);
  assign sda_line = ~(sda_oe | slave_sda_low);

  always #5 clk = ~clk;

  iic_bit_phy #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_bit(cmd_bit), .rsp_valid(rsp_valid), .rsp_bit(rsp_bit),
    .arb_lost(arb_lost), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_i(scl_line), .sda_i(sda_line)
  );

  // Slave stretch: once the master releases SCL, keep it low for stretch_len more edges
  initial forever begin
    @(negedge scl_oe);
    if (stretch_arm) begin
      stretch_arm = 1'b0;
      repeat (stretch_len) @(posedge clk);
      #1 slave_scl_low = 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; slave_scl_low = 1'b0; slave_sda_low = 1'b0;
    stretch_arm = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_scl = 1'b0; m_sda = 1'b0; m_rsp = 1'b0;
  endtask

  // Issues one command from a negedge and returns at the negedge where rsp_valid is seen
  task automatic run_cmd(input logic [1:0] c, input logic b, input logic sda_low,
                         input int unsigned s, input logic spam,
                         output int unsigned lat, output int unsigned sda_fall,
                         output int unsigned scl_fall, output logic arb_q_bad,
                         output logic sda_bad);
    logic prev_scl, prev_sda;
    chk("ready_before_accept", cmd_ready, 1);
    slave_sda_low = sda_low;
    if (s > 0) begin
      slave_scl_low = 1'b1;
      stretch_len   = s;
      stretch_arm   = 1'b1;
    end
    cmd = c; cmd_bit = b; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = spam; cmd = 2'($urandom); cmd_bit = 1'($urandom);
    lat = 0; sda_fall = 0; scl_fall = 0; arb_q_bad = 1'b0; sda_bad = 1'b0;
    prev_scl = scl_line; prev_sda = sda_line;
    while (!rsp_valid && lat < LIMIT) begin
      if (arb_lost) arb_q_bad = 1'b1;
      @(negedge clk);
      lat++;
      if (lat == 2 * CLK_DIV) cmd_valid = 1'b0;
      if (prev_sda && !sda_line && sda_fall == 0) sda_fall = lat;
      if (prev_scl && !scl_line && scl_fall == 0) scl_fall = lat;
      if (c[1] && prev_scl && scl_line && (prev_sda != sda_line)) sda_bad = 1'b1;
      prev_scl = scl_line; prev_sda = sda_line;
    end
    cmd_valid = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
    chk("ready_at_rsp", cmd_ready, 1);
    chk("busy_at_rsp", busy, 0);
    slave_sda_low = 1'b0;
  endtask

  task automatic check_cmd(input string tag, input logic [1:0] c, input logic b,
                           input logic sda_low, input int unsigned s, input logic spam,
                           input int unsigned e_lat, input logic e_bit, input logic e_arb,
                           input logic e_scl, input logic e_sda);
    int unsigned lat, sf, cf;
    logic aq, sb;
    run_cmd(c, b, sda_low, s, spam, lat, sf, cf, aq, sb);
    chk($sformatf("%s latency", tag), lat, e_lat);
    chk($sformatf("%s rsp_bit", tag), rsp_bit, e_bit);
    chk($sformatf("%s arb_lost", tag), arb_lost, e_arb);
    chk($sformatf("%s scl_oe", tag), scl_oe, e_scl);
    chk($sformatf("%s sda_oe", tag), sda_oe, e_sda);
    chk($sformatf("%s arb_qualified", tag), aq, 0);
    if (c[1]) chk($sformatf("%s sda_stable_scl_high", tag), sb, 0);
  endtask

  // Bus-level expectation: bit value seen on the wire, who owns the lines afterwards,
  // and how long SCL is seen low at the start of the high phase
  task automatic model_cmd(input logic [1:0] c, input logic b, input logic sda_low,
                           input int unsigned s, output int unsigned e_lat,
                           output logic e_bit, output logic e_arb,
                           output logic e_scl, output logic e_sda);
    logic scl_low_before_high;
    logic lost;
    scl_low_before_high = (c == C_START) ? m_scl : 1'b1;
    e_lat = 4 * CLK_DIV + (scl_low_before_high ? s + 2 : 0);
    lost  = (c == C_WRITE) && b && sda_low;
    e_arb = lost;
    case (c)
      C_START: begin m_scl = 1'b1; m_sda = 1'b1; end
      C_STOP:  begin m_scl = 1'b0; m_sda = 1'b0; end
      C_WRITE: begin
        m_rsp = b & ~sda_low;
        m_scl = ~lost;
        m_sda = ~b & ~lost;
      end
      default: begin
        m_rsp = ~sda_low;
        m_scl = 1'b1;
        m_sda = 1'b0;
      end
    endcase
    e_bit = m_rsp; e_scl = m_scl; e_sda = m_sda;
  endtask

  task automatic model_check(input string tag, input logic [1:0] c, input logic b,
                             input logic sda_low, input int unsigned s, input logic spam);
    int unsigned e_lat;
    logic e_bit, e_arb, e_scl, e_sda;
    model_cmd(c, b, sda_low, s, e_lat, e_bit, e_arb, e_scl, e_sda);
    check_cmd(tag, c, b, sda_low, s, spam, e_lat, e_bit, e_arb, e_scl, e_sda);
  endtask

  task automatic abort_read(input string tag, input int unsigned at_lat,
                            input logic pre_scl, input logic pre_rsp);
    int unsigned pulses;
    slave_sda_low = 1'b0;
    cmd = C_READ; cmd_bit = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (at_lat) @(negedge clk);
    chk($sformatf("%s busy_before", tag), busy, 1);
    chk($sformatf("%s scl_oe_before", tag), scl_oe, pre_scl);
    chk($sformatf("%s rsp_bit_before", tag), rsp_bit, pre_rsp);
    reset = 1'b1;
    #1;
    chk($sformatf("%s scl_oe_reset", tag), scl_oe, 0);
    chk($sformatf("%s sda_oe_reset", tag), sda_oe, 0);
    chk($sformatf("%s ready_reset", tag), cmd_ready, 1);
    chk($sformatf("%s rsp_bit_reset", tag), rsp_bit, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk($sformatf("%s no_rsp_after_abort", tag), pulses, 0);
    m_scl = 1'b0; m_sda = 1'b0; m_rsp = 1'b0;
  endtask

  initial begin
    int unsigned lat, sf, cf;
    logic aq, sb;
    logic [1:0] rc;
    logic rb, rsl, pre;
    int unsigned rs;

    reset = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_bit = 1'b0;
    slave_scl_low = 1'b0; slave_sda_low = 1'b0; stretch_arm = 1'b0; stretch_len = 0;
    m_scl = 1'b0; m_sda = 1'b0; m_rsp = 1'b0;

    vecs[0]  = '{C_START, 1'b0, 1'b0, 0,  LAT0,      1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{C_WRITE, 1'b1, 1'b0, 0,  LAT2,      1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{C_WRITE, 1'b0, 1'b0, 0,  LAT2,      1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{C_WRITE, 1'b1, 1'b0, 0,  LAT2,      1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{C_WRITE, 1'b0, 1'b0, 0,  LAT2,      1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{C_READ,  1'b0, 1'b1, 0,  LAT2,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{C_READ,  1'b0, 1'b0, 0,  LAT2,      1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{C_WRITE, 1'b1, 1'b0, 20, LAT2 + 20, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{C_STOP,  1'b0, 1'b0, 0,  LAT2,      1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{C_START, 1'b0, 1'b0, 0,  LAT0,      1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{C_WRITE, 1'b1, 1'b1, 0,  LAT2,      1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{C_STOP,  1'b0, 1'b0, 0,  LAT2,      1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset scl_oe", scl_oe, 0);
    chk("reset sda_oe", sda_oe, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_bit", rsp_bit, 0);
    chk("reset arb_lost", arb_lost, 0);
    reset = 1'b0;
    @(negedge clk);

    // START from idle bus: SDA falls at the C phase with SCL high, SCL falls at D
    run_cmd(C_START, 1'b0, 1'b0, 0, 1'b0, lat, sf, cf, aq, sb);
    chk("start latency", lat, 4 * CLK_DIV);
    chk("start sda_fall", sf, 2 * CLK_DIV);
    chk("start scl_fall", cf, 3 * CLK_DIV);
    chk("start scl_oe", scl_oe, 1);
    chk("start sda_oe", sda_oe, 1);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      check_cmd($sformatf("vec%0d", i), vecs[i].c, vecs[i].b, vecs[i].sl, vecs[i].s,
                1'(i % 2), vecs[i].lat, vecs[i].rb, vecs[i].arb, vecs[i].scl, vecs[i].sda);
    end

    do_reset();
    abort_read("abortA", 2, 1'b1, 1'b0);
    model_check("postA_start", C_START, 1'b0, 1'b0, 0, 1'b0);
    abort_read("abortC", 3 * CLK_DIV, 1'b0, 1'b1);
    model_check("postC_stop", C_STOP, 1'b0, 1'b0, 0, 1'b0);
    model_check("postC_start", C_START, 1'b0, 1'b0, 0, 1'b0);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      rc  = 2'($urandom);
      rb  = 1'($urandom);
      rsl = (rc[1]) ? 1'($urandom) : 1'b0;
      pre = (rc == C_START) ? m_scl : 1'b1;
      rs  = (pre && ($urandom_range(0, 2) == 0)) ? $urandom_range(1, 12) : 0;
      model_check($sformatf("rand%0d", i), rc, rb, rsl, rs, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_bit_phy.md
Name: iic_bit_phy

Overview:
Bit-level IIC physical engine sitting directly below the IIC byte core. It executes one bus primitive per command (START, STOP, WRITE bit, READ bit), generates SCL/SDA timing from the system clock, and drives both lines open-drain. It also supports slave clock stretching and reports arbitration loss. The top level converts the *_oe outputs into tristate pads; the byte core sequences commands through a valid/ready handshake.

Parameters:
CLK_DIV, 250, clk cycles per quarter SCL period (SCL period = 4*CLK_DIV; 100 MHz -> 100 kHz); legal range 2..65535
DIV_W, 16, width of phase counter; must hold CLK_DIV-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, command accepted when cmd_valid && cmd_ready at clk edge
cmd  in  2  00 START, 01 STOP, 10 WRITE, 11 READ
cmd_bit  in  1  data bit for WRITE (ignored otherwise)
rsp_valid  out  1  one-cycle pulse, command complete
rsp_bit  out  1  SDA value sampled in phase C (WRITE/READ); held until next update
arb_lost  out  1  qualifies rsp_valid: arbitration lost during this WRITE
busy  out  1  command in progress (= !cmd_ready)
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_i  in  1  SCL pad input (async)
sda_i  in  1  SDA pad input (async)

Behaviour:
- Reset (async): scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_bit=0, arb_lost=0, counter=0, state IDLE. Reset mid-command releases both lines immediately; no rsp_valid is generated.
- scl_i and sda_i each pass through a 2-flop synchronizer; all sampling uses the synchronized values.
- States: IDLE, PH_A, PH_B, PH_C, PH_D. On accept, latch cmd/cmd_bit and enter PH_A next cycle. Each phase lasts CLK_DIV cycles; the counter runs 0..CLK_DIV-1, then advances.
- Clock stretching: in PH_B, the counter holds at 0 while synchronized SCL = 0. Counting starts on the first cycle synchronized SCL = 1. Stretching is not checked in other phases.
- Line drive per phase (scl_oe/sda_oe):
  - START: A keep scl_oe, sda_oe=0 | B scl_oe=0, sda_oe=0 | C scl_oe=0, sda_oe=1 | D scl_oe=1, sda_oe=1.
  - STOP: A scl_oe=1, sda_oe=1 | B scl_oe=0, sda_oe=1 | C scl_oe=0, sda_oe=0 | D scl_oe=0, sda_oe=0.
  - WRITE: A scl_oe=1, sda_oe=~bit | B scl_oe=0 | C scl_oe=0 | D scl_oe=1; sda_oe held from A.
  - READ: identical to WRITE with sda_oe=0 in all phases.
- Sampling: on the first cycle of PH_C, rsp_bit <= synchronized SDA (WRITE/READ only). START/STOP leave rsp_bit unchanged.
- Arbitration: WRITE with bit=1 and sampled SDA=0 sets the internal lost flag. sda_oe is forced 0 from then on; remaining phases run normally. At completion scl_oe=0 (line state fully released), and arb_lost=1 together with rsp_valid.
- Completion: the cycle after the last PH_D count, state returns to IDLE. In that cycle rsp_valid=1 and cmd_ready=1, so back-to-back accept in the same cycle is permitted. arb_lost is 0 whenever rsp_valid=0.
- Latency without stretching: accept at edge 0 -> rsp_valid on cycle 4*CLK_DIV+1.
- scl_oe/sda_oe persist in IDLE. After START/WRITE/READ: SCL held low. After STOP or arb loss: both released.
- cmd_valid while busy: ignored, not latched. READ/WRITE without a preceding START: executed as specified, no error.

Test Plan:
- CLK_DIV=4, scl_i/sda_i tied to wired-AND of outputs: START -> SDA falls while SCL high, then SCL falls; rsp_valid exactly at cycle 17 after accept; final scl_oe=1, sda_oe=1.
- WRITE bits 1,0,1,0 after START -> SDA stable during each SCL-high window; rsp_bit = 1,0,1,0; arb_lost=0.
- READ with modelled slave holding SDA low -> rsp_bit=0; with SDA released -> rsp_bit=1; sda_oe=0 throughout.
- Slave holds SCL low 20 cycles into PH_B of a WRITE -> PH_B extends by 20 + sync latency; rsp_valid delayed by the same amount.
- WRITE bit=1 with external SDA forced low -> sda_oe=0, rsp_valid with arb_lost=1, rsp_bit=0; final scl_oe=0, sda_oe=0.
- Assert reset in PH_C of READ -> scl_oe=sda_oe=0 immediately, no rsp_valid; STOP then START after release execute normally.
